// File: rtl/wb_stage.sv
// wb_stage: M/W writeback latches feeding the register-file write port,
// plus operand bypass to decode, load-use detection and a retire counter.
module wb_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ExValid,
  input  logic        ExRegWre,
  input  logic        ExMemRead,
  input  logic [3:0]  ExWriteReg,
  input  logic [15:0] ExResult,
  input  logic [15:0] MemRdData,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [3:0]  Rs,
  input  logic [3:0]  Rt,
  input  logic [15:0] RfData1,
  input  logic [15:0] RfData2,
  output logic        RegWre,
  output logic [3:0]  WriteReg,
  output logic [15:0] WriteData,
  output logic [15:0] FwdData1,
  output logic [15:0] FwdData2,
  output logic        LoadUseStall,
  output logic [15:0] RetireCount
);

  // Register encodings shared with the register file.
  localparam logic [3:0] REG0 = 4'd0;
  localparam logic [3:0] T    = 4'd14;
  localparam logic [3:0] PC   = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        regwre;
    logic        load;
    logic [3:0]  dst;
    logic [15:0] data;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t      m_q, m_d, w_q, w_d, m_adv;
  logic [15:0] cnt_q, cnt_d;
  logic        reg_wre;

  // Value a producer presents to consumers; T reads back as a flag.
  function automatic logic [15:0] eff_val(input stage_t s);
    if (s.dst == T) return {15'b0, (s.data == 16'h0000)};
    return s.data;
  endfunction

  always_comb begin
    m_adv = m_q;
    if (m_q.load) m_adv.data = MemRdData;
    m_d = m_q;
    w_d = m_adv;
    if (Flush) begin
      m_d = BUBBLE;
    end else if (Stall) begin
      w_d = BUBBLE;
    end else begin
      m_d = {ExValid, ExRegWre, ExMemRead, ExWriteReg, ExResult};
    end
  end

  assign reg_wre = w_q.valid & w_q.regwre & (w_q.dst != REG0);
  assign cnt_d   = cnt_q + {15'b0, reg_wre};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_q   <= BUBBLE;
      w_q   <= BUBBLE;
      cnt_q <= 16'h0000;
    end else begin
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign RegWre      = reg_wre;
  assign WriteReg    = w_q.dst;
  assign WriteData   = w_q.data;
  assign RetireCount = cnt_q;

  logic [1:0][3:0]  src;
  logic [1:0][15:0] rf_rd;
  logic [1:0][15:0] fwd;

  assign src   = {Rt, Rs};
  assign rf_rd = {RfData2, RfData1};

  // A load in M has no data yet; the hazard logic holds decode instead.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic pinned, m_hit, w_hit;
    assign pinned = (src[gi] == REG0) | (src[gi] == PC);
    assign m_hit  = m_q.valid & m_q.regwre & ~m_q.load & (m_q.dst == src[gi]);
    assign w_hit  = w_q.valid & w_q.regwre & (w_q.dst == src[gi]);
    assign fwd[gi] = pinned ? rf_rd[gi] :
                     m_hit  ? eff_val(m_q) :
                     w_hit  ? eff_val(w_q) : rf_rd[gi];
  end

  assign FwdData1 = fwd[0];
  assign FwdData2 = fwd[1];

  assign LoadUseStall = m_q.valid & m_q.regwre & m_q.load & (m_q.dst != REG0) &
                        ((m_q.dst == Rs) | (m_q.dst == Rt));

endmodule
